fab_frame_loader: RTL and testbench

//  Upstream stage of the fabric configuration latches (LHQD1 cells driving the
//  cus_mux41/81/161 select inputs). Accepts a 32-bit word stream, assembles one

---
 rtl/fab_cfg_pkg.sv | 22 ++
 rtl/fab_frame_strobe_dec.sv | 26 ++
 rtl/fab_frame_loader.sv | 147 ++++++++++++++
 tb/tb_fab_frame_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fab_cfg_pkg.sv
// Shared definitions for the fabric configuration frame loader: FSM states,
// default sync word and header field positions.
package fab_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHK    = 3'd3,
        ST_STROBE = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    localparam logic [31:0] SYNC_WORD_DEF = 32'hFAB0_FAB1;

    localparam int DESYNC_BIT = 31;
    localparam int COL_MSB    = 23;
    localparam int COL_LSB    = 16;
    localparam int FRAME_MSB  = 7;
    localparam int FRAME_LSB  = 0;

endpackage

// File: rtl/fab_frame_strobe_dec.sv
// Decodes a {column, frame} address into a one-hot latch enable; flags range.
// Latency: combinational. Backpressure: none.
module fab_frame_strobe_dec #(
    parameter int NUM_COLS       = 8,
    parameter int FRAMES_PER_COL = 20
) (
    input  logic [7:0]                         i_col,
    input  logic [7:0]                         i_frame,
    input  logic                               i_en,
    output logic [NUM_COLS*FRAMES_PER_COL-1:0] o_strobe,
    output logic                               o_in_range
);

    int w_idx;

    assign o_in_range = (int'(i_col) < NUM_COLS) && (int'(i_frame) < FRAMES_PER_COL);
    assign w_idx      = int'(i_col) * FRAMES_PER_COL + int'(i_frame);

    always_comb begin
        o_strobe = '0;
        for (int i = 0; i < NUM_COLS * FRAMES_PER_COL; i++) begin
            o_strobe[i] = i_en && o_in_range && (w_idx == i);
        end
    end

endmodule

// File: rtl/fab_frame_loader.sv
// Assembles config frames from a word stream and strobes one latch row per frame.
// Latency: strobe starts the cycle after the last frame word, held STROBE_CYCLES, then 1 gap cycle.
// Backpressure: s_ready low during strobe+gap; FAB_LOADER_CHECKSUM_EN adds a checksum word per frame.
module fab_frame_loader
    import fab_cfg_pkg::*;
#(
    parameter int                 DATA_W          = 32,
    parameter int                 WORDS_PER_FRAME = 1,
    parameter int                 NUM_COLS        = 8,
    parameter int                 FRAMES_PER_COL  = 20,
    parameter int                 STROBE_CYCLES   = 2,
    parameter logic [DATA_W-1:0]  SYNC_WORD       = SYNC_WORD_DEF
) (
    input  logic                                 CLK,
    input  logic                                 resetn,
    input  logic [DATA_W-1:0]                    s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [DATA_W*WORDS_PER_FRAME-1:0]    FrameData,
    output logic [NUM_COLS*FRAMES_PER_COL-1:0]   FrameStrobe,
    output logic                                 busy,
    output logic                                 configured,
    output logic                                 err
);

    localparam int FW   = DATA_W * WORDS_PER_FRAME;
    localparam int WC_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int SC_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    state_t            r_state;
    logic [7:0]        r_col;
    logic [7:0]        r_frame;
    logic [WC_W-1:0]   r_wcnt;
    logic [SC_W-1:0]   r_scnt;
    logic [FW-1:0]     r_data;
    logic              r_ok;
    logic              r_configured;
    logic              r_err;
`ifdef FAB_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_chk;
`endif

    logic w_xfer;
    logic w_last_word;
    logic w_in_range;

    assign s_ready     = (r_state == ST_IDLE) || (r_state == ST_HDR) ||
                         (r_state == ST_DATA) || (r_state == ST_CHK);
    assign w_xfer      = s_valid && s_ready;
    assign w_last_word = (r_wcnt == WC_W'(WORDS_PER_FRAME - 1));

    assign FrameData  = r_data;
    assign busy       = (r_state != ST_IDLE);
    assign configured = r_configured;
    assign err        = r_err;

    // Strobe is a pure decode of state so an async reset drops it immediately.
    fab_frame_strobe_dec #(
        .NUM_COLS       (NUM_COLS),
        .FRAMES_PER_COL (FRAMES_PER_COL)
    ) u_dec (
        .i_col      (r_col),
        .i_frame    (r_frame),
        .i_en       ((r_state == ST_STROBE) && r_ok),
        .o_strobe   (FrameStrobe),
        .o_in_range (w_in_range)
    );

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_frame      <= '0;
            r_wcnt       <= '0;
            r_scnt       <= '0;
            r_data       <= '0;
            r_ok         <= 1'b0;
            r_configured <= 1'b0;
            r_err        <= 1'b0;
`ifdef FAB_LOADER_CHECKSUM_EN
            r_chk        <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer && (s_data == SYNC_WORD)) begin
                        r_state      <= ST_HDR;
                        r_err        <= 1'b0;
                        r_configured <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (w_xfer) begin
                        if (s_data[DESYNC_BIT]) begin
                            r_state      <= ST_IDLE;
                            r_configured <= 1'b1;
                        end else begin
                            r_col   <= s_data[COL_MSB:COL_LSB];
                            r_frame <= s_data[FRAME_MSB:FRAME_LSB];
                            r_wcnt  <= '0;
                            r_state <= ST_DATA;
`ifdef FAB_LOADER_CHECKSUM_EN
                            r_chk   <= s_data;
`endif
                        end
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_data <= (r_data << DATA_W) | FW'(s_data);
                        r_wcnt <= r_wcnt + 1'b1;
`ifdef FAB_LOADER_CHECKSUM_EN
                        r_chk  <= r_chk ^ s_data;
                        if (w_last_word) r_state <= ST_CHK;
`else
                        if (w_last_word) begin
                            r_state <= ST_STROBE;
                            r_scnt  <= '0;
                            r_ok    <= w_in_range;
                            if (!w_in_range) r_err <= 1'b1;
                        end
`endif
                    end
                end
                ST_CHK: begin
`ifdef FAB_LOADER_CHECKSUM_EN
                    if (w_xfer) begin
                        r_state <= ST_STROBE;
                        r_scnt  <= '0;
                        r_ok    <= w_in_range && (s_data == r_chk);
                        if (!w_in_range || (s_data != r_chk)) r_err <= 1'b1;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                ST_STROBE: begin
                    if (r_scnt == SC_W'(STROBE_CYCLES - 1)) r_state <= ST_GAP;
                    else                                   r_scnt  <= r_scnt + 1'b1;
                end
                ST_GAP:  r_state <= ST_HDR;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fab_frame_loader.sv
// Self-checking bench for fab_frame_loader: directed table, hand sequences and
// randomized frames scored against an address/flag model.
module tb_fab_frame_loader;

    localparam int NC   = 8;
    localparam int FPC  = 20;
    localparam int NS   = NC * FPC;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic            CLK = 1'b0;
    logic            resetn = 1'b0;
    logic [31:0]     s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [31:0]     FrameData;
    logic [NS-1:0]   FrameStrobe;
    logic            busy, configured, err;

    int total = 0;
    int bad   = 0;
    bit m_err = 1'b0;

    fab_frame_loader dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .configured  (configured),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  col;
        logic [7:0]  frame;
        logic [31:0] data;
        bit          gaps;
        bit          exp_hit;
        int          exp_idx;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word is transferred.
    task automatic send(input logic [31:0] w, input bit gaps);
        int budget = 200;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                s_valid = 1'b0;
                s_data  = $urandom;
                @(negedge CLK);
            end
        end
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (budget == 0) begin
            total++; bad++;
            $display("FAIL send_timeout: got s_ready=0 expected 1");
        end
        @(posedge CLK);
        @(negedge CLK);
        s_valid = 1'b0;
        s_data  = $urandom;
    endtask

    task automatic load_frame(input logic [7:0] col, input logic [7:0] fr, input logic [31:0] d,
                              input bit gaps, input bit bad_chk,
                              input bit exp_hit, input int exp_idx, input bit exp_err);
        logic [31:0]   hdr;
        logic [NS-1:0] ev;
        hdr = {8'h00, col, 8'h00, fr};
        ev  = '0;
        if (exp_hit) ev[exp_idx] = 1'b1;
        send(hdr, gaps);
        send(d, gaps);
`ifdef FAB_LOADER_CHECKSUM_EN
        send(bad_chk ? ~(hdr ^ d) : (hdr ^ d), gaps);
`endif
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("strobe_c%0d", c), FrameStrobe, (c < 2) ? ev : '0);
            chk($sformatf("ready_c%0d", c), NS'(s_ready), NS'(0));
            chk($sformatf("fdata_c%0d", c), NS'(FrameData), NS'(d));
            @(negedge CLK);
        end
        chk("ready_after_gap", NS'(s_ready), NS'(1));
        chk("err_after_frame", NS'(err), NS'(exp_err));
    endtask

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rc, rf;
        logic [31:0] rd;
        bit          hit;

        tbl[0] = '{8'd2, 8'd5,  32'hA5A5_0F0F, 1'b0, 1'b1, 45,  1'b0};
        tbl[1] = '{8'd8, 8'd0,  32'h1111_2222, 1'b0, 1'b0, 0,   1'b1};
        tbl[2] = '{8'd0, 8'd0,  32'hDEAD_BEEF, 1'b0, 1'b1, 0,   1'b1};
        tbl[3] = '{8'd7, 8'd19, SYNC,          1'b0, 1'b1, 159, 1'b1};
        tbl[4] = '{8'd0, 8'd20, 32'h0000_0001, 1'b0, 1'b0, 0,   1'b1};
        tbl[5] = '{8'd3, 8'd7,  32'h8000_0000, 1'b1, 1'b1, 67,  1'b1};

        // Test 1: reset state, junk ignored, sync starts session
        repeat (3) @(negedge CLK);
        chk("rst_strobe", FrameStrobe, '0);
        chk("rst_fdata", NS'(FrameData), NS'(0));
        chk("rst_busy", NS'(busy), NS'(0));
        chk("rst_cfg", NS'(configured), NS'(0));
        chk("rst_err", NS'(err), NS'(0));
        resetn = 1'b1;
        @(negedge CLK);
        chk("idle_ready", NS'(s_ready), NS'(1));
        send(32'h1234_5678, 1'b0);
        chk("junk_busy", NS'(busy), NS'(0));
        send(SYNC, 1'b0);
        chk("sync_busy", NS'(busy), NS'(1));

        // Tests 2/3 and table frames (including SYNC as data and toggled valid)
        for (int i = 0; i < 6; i++) begin
            load_frame(tbl[i].col, tbl[i].frame, tbl[i].data, tbl[i].gaps, 1'b0,
                       tbl[i].exp_hit, tbl[i].exp_idx, tbl[i].exp_err);
        end
        m_err = 1'b1;

        // Test 4: desync, then resync clears flags
        send(32'h8000_0000, 1'b0);
        chk("desync_busy", NS'(busy), NS'(0));
        chk("desync_cfg", NS'(configured), NS'(1));
        chk("desync_err_kept", NS'(err), NS'(1));
        send(SYNC, 1'b0);
        m_err = 1'b0;
        chk("resync_cfg", NS'(configured), NS'(0));
        chk("resync_err", NS'(err), NS'(0));
        chk("resync_busy", NS'(busy), NS'(1));

        // Test 5: same frame as test 2 with randomly stalled valid
        load_frame(8'd2, 8'd5, 32'hA5A5_0F0F, 1'b1, 1'b0, 1'b1, 45, 1'b0);

        // Randomized frames against the address/flag model
        for (int n = 0; n < 24; n++) begin
            rc  = 8'($urandom_range(0, 9));
            rf  = 8'($urandom_range(0, 22));
            rd  = $urandom;
            hit = (int'(rc) < NC) && (int'(rf) < FPC);
            if (!hit) m_err = 1'b1;
            load_frame(rc, rf, rd, n[0], 1'b0, hit, int'(rc) * FPC + int'(rf), m_err);
        end

`ifdef FAB_LOADER_CHECKSUM_EN
        // Wrong checksum: frame consumes strobe timing but drives nothing
        send(32'h8000_0000, 1'b0);
        send(SYNC, 1'b0);
        load_frame(8'd1, 8'd1, 32'h0F0F_F0F0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        load_frame(8'd1, 8'd2, 32'h0F0F_F0F1, 1'b0, 1'b0, 1'b1, 22, 1'b1);
`endif

        // Test 6: async reset during strobe
        send({8'h00, 8'd4, 8'h00, 8'd3}, 1'b0);
        send(32'h5555_AAAA, 1'b0);
`ifdef FAB_LOADER_CHECKSUM_EN
        send({8'h00, 8'd4, 8'h00, 8'd3} ^ 32'h5555_AAAA, 1'b0);
`endif
        begin
            logic [NS-1:0] ev;
            ev = '0;
            ev[83] = 1'b1;
            chk("pre_rst_strobe", FrameStrobe, ev);
        end
        #2 resetn = 1'b0;
        #1;
        chk("arst_strobe", FrameStrobe, '0);
        chk("arst_busy", NS'(busy), NS'(0));
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        chk("arst_idle_ready", NS'(s_ready), NS'(1));
        chk("arst_still_idle", NS'(busy), NS'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
